// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft.
// master: producer/consumer side (drives wr_en, wdata, rd_en, clr_err).
// slave : FIFO side (drives rdata, rvalid, status flags, count and error flags).
interface sync_fifo_fwft_if #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
);
    logic                wr_en;
    logic [DATASIZE-1:0] wdata;
    logic                rd_en;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                wr_full;
    logic                rempty;
    logic                almost_full;
    logic                almost_empty;
    logic [ADDRSIZE:0]   count;
    logic                clr_err;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_en, wdata, rd_en, clr_err,
        input  rdata, rvalid, wr_full, rempty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, clr_err,
        output rdata, rvalid, wr_full, rempty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard (registered, 1-cycle latency) or
// first-word-fall-through read mode, almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags.
// Ports:
//   clk - clock, all state changes on the rising edge
//   rst - asynchronous active-high reset
//   bus - sync_fifo_fwft_if.slave: write/read handshake, data, status, errors
module sync_fifo_fwft #(
    parameter int unsigned DATASIZE      = 8,
    parameter int unsigned ADDRSIZE      = 4,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = 2**ADDRSIZE - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_fwft_if.slave bus
);
    localparam int unsigned       Depth    = 2**ADDRSIZE;
    localparam logic [ADDRSIZE:0] PtrOne   = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE:0] AfThresh = AFULL_THRESH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AeThresh = AEMPTY_THRESH[ADDRSIZE:0];

    if (AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_bad_afull
        $error("sync_fifo_fwft: AFULL_THRESH out of range 1..2**ADDRSIZE");
    end
    if (AEMPTY_THRESH > Depth - 1) begin : g_bad_aempty
        $error("sync_fifo_fwft: AEMPTY_THRESH out of range 0..2**ADDRSIZE-1");
    end

    logic [DATASIZE-1:0] mem [Depth];
    logic [ADDRSIZE:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDRSIZE-1:0] wr_addr, rd_addr;
    logic [ADDRSIZE:0]   occupancy;
    logic                full, empty, do_wr, do_rd;
    logic                overflow_q, underflow_q;

    assign wr_addr   = wr_ptr_q[ADDRSIZE-1:0];
    assign rd_addr   = rd_ptr_q[ADDRSIZE-1:0];
    // Extra wrap bit makes the plain difference the exact occupancy 0..Depth.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (wr_ptr_q[ADDRSIZE] != rd_ptr_q[ADDRSIZE]) && (wr_addr == rd_addr);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    // Gating on the registered flags means a write into an empty FIFO cannot
    // satisfy a same-cycle read, and a read from a full FIFO cannot make room.
    assign do_wr     = bus.wr_en && !full;
    assign do_rd     = bus.rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_addr] <= bus.wdata;
    end

    // Sticky errors: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full)       overflow_q <= 1'b1;
            else if (bus.clr_err)        overflow_q <= 1'b0;
            if (bus.rd_en && empty)      underflow_q <= 1'b1;
            else if (bus.clr_err)        underflow_q <= 1'b0;
        end
    end

    assign bus.count        = occupancy;
    assign bus.wr_full      = full;
    assign bus.rempty       = empty;
    assign bus.almost_full  = (occupancy >= AfThresh);
    assign bus.almost_empty = (occupancy <= AeThresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; rd_en only acknowledges it.
        assign bus.rdata  = empty ? '0 : mem[rd_addr];
        assign bus.rvalid = !empty;
    end else begin : g_std
        logic [DATASIZE-1:0] rdata_q;
        logic                rvalid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= do_rd;
                if (do_rd) rdata_q <= mem[rd_addr];
            end
        end

        assign bus.rdata  = rdata_q;
        assign bus.rvalid = rvalid_q;
    end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench: one standard-mode and one FWFT-mode instance driven with
// identical stimulus and compared against a queue-based reference model, plus
// a table of hand-derived vectors and directed corner-case sequences.
module tb_sync_fifo_fwft;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_fwft_if #(.DATASIZE(8), .ADDRSIZE(4)) bus_s ();
    sync_fifo_fwft_if #(.DATASIZE(8), .ADDRSIZE(4)) bus_f ();

    sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       m_ovf, m_unf, m_rv;
    logic [7:0] m_rdata;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       ce;
        int         cnt;
        logic       emp;
        logic       rv;
        logic [7:0] rd;
        logic [7:0] frd;
        logic       unf;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] wd, input logic re,
                              input logic ce);
        int n;
        bit dr, dw;
        n  = q.size();
        dr = re && (n > 0);
        dw = we && (n < 16);
        if (we && n == 16) m_ovf = 1'b1;
        else if (ce)       m_ovf = 1'b0;
        if (re && n == 0)  m_unf = 1'b1;
        else if (ce)       m_unf = 1'b0;
        m_rv = dr;
        if (dr) m_rdata = q.pop_front();
        if (dw) q.push_back(wd);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, " count_s"}, 32'(bus_s.count), n);
        chk({tag, " count_f"}, 32'(bus_f.count), n);
        chk({tag, " rempty_s"}, bus_s.rempty, n == 0);
        chk({tag, " rempty_f"}, bus_f.rempty, n == 0);
        chk({tag, " full_s"}, bus_s.wr_full, n == 16);
        chk({tag, " full_f"}, bus_f.wr_full, n == 16);
        chk({tag, " afull"}, bus_s.almost_full, n >= 14);
        chk({tag, " aempty"}, bus_f.almost_empty, n <= 2);
        chk({tag, " ovf_s"}, bus_s.overflow, m_ovf);
        chk({tag, " ovf_f"}, bus_f.overflow, m_ovf);
        chk({tag, " unf_s"}, bus_s.underflow, m_unf);
        chk({tag, " unf_f"}, bus_f.underflow, m_unf);
        chk({tag, " rvalid_s"}, bus_s.rvalid, m_rv);
        chk({tag, " rdata_s"}, bus_s.rdata, m_rdata);
        chk({tag, " rvalid_f"}, bus_f.rvalid, n != 0);
        chk({tag, " rdata_f"}, bus_f.rdata, (n != 0) ? q[0] : 8'h00);
    endtask

    task automatic drive(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        bus_s.wr_en = we; bus_s.wdata = wd; bus_s.rd_en = re; bus_s.clr_err = ce;
        bus_f.wr_en = we; bus_f.wdata = wd; bus_f.rd_en = re; bus_f.clr_err = ce;
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic ce,
                         input string tag);
        @(negedge clk);
        drive(we, wd, re, ce);
        @(posedge clk);
        model_edge(we, wd, re, ce);
        #1;
        check_all(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, e;
        // we wd re ce | cnt emp rv rd frd unf  (from empty, after reset)
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1};
        vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'h22, 8'h33, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h22, 8'h33, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0};

        // Reset defaults
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset rempty", bus_s.rempty, 1'b1);
        chk("reset afull", bus_f.almost_full, 1'b0);
        chk("reset aempty", bus_s.almost_empty, 1'b1);
        chk("reset rvalid", bus_s.rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ce, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d count", i), 32'(bus_s.count), vecs[i].cnt);
            chk($sformatf("vec%0d rempty", i), bus_s.rempty, vecs[i].emp);
            chk($sformatf("vec%0d rvalid", i), bus_s.rvalid, vecs[i].rv);
            chk($sformatf("vec%0d rdata", i), bus_s.rdata, vecs[i].rd);
            chk($sformatf("vec%0d fwft_rdata", i), bus_f.rdata, vecs[i].frd);
            chk($sformatf("vec%0d underflow", i), bus_s.underflow, vecs[i].unf);
        end

        // Fill ordering
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            chk("fill afull", bus_s.almost_full, i >= 13);
            chk("fill full", bus_s.wr_full, i == 15);
        end
        // Write while full with a read: data dropped, overflow set
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, "ovf");
        chk("ovf count", 32'(bus_s.count), 15);
        chk("ovf flag", bus_s.overflow, 1'b1);
        chk("ovf rdata", bus_s.rdata, 8'h00);
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
            chk("drain order", bus_s.rdata, 8'(i));
        end
        chk("drain empty", bus_s.rempty, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "unf");
        chk("unf flag", bus_s.underflow, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr ovf", bus_s.overflow, 1'b0);
        chk("clr unf", bus_f.underflow, 1'b0);

        // FWFT latency
        cycle(1'b1, 8'h5C, 1'b0, 1'b0, "fwft_wr");
        chk("fwft rempty", bus_f.rempty, 1'b0);
        chk("fwft rdata", bus_f.rdata, 8'h5C);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");
        chk("fwft pop empty", bus_f.rempty, 1'b1);

        // Wrap with concurrent traffic at count 8
        d = 8'h80;
        e = 8'h80;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, d, 1'b0, 1'b0, "wrap_fill");
            d++;
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, d, 1'b1, 1'b0, "wrap");
            d++;
            chk("wrap count", 32'(bus_s.count), 8);
            chk("wrap order", bus_s.rdata, e);
            e++;
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

        // Randomised traffic with phases biased toward full and toward empty
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = ((i / 50) % 2 == 0) ? 3 : 1;
            cycle(($urandom % 4) < wbias, 8'($urandom), ($urandom % 4) >= wbias - 1 && ($urandom % 2 == 1),
                  ($urandom % 16) == 0, "rand");
        end

        // Mid-operation reset at count 5
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst");
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_rst_fill");
        chk("pre_rst count", 32'(bus_s.count), 5);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst count", 32'(bus_s.count), 0);
        chk("rst rempty", bus_f.rempty, 1'b1);
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_wr");
        chk("post_rst fwft", bus_f.rdata, 8'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");
        chk("post_rst rdata", bus_s.rdata, 8'h77);
        chk("post_rst empty", bus_s.rempty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised FIFO for the AXI-to-I2C bridge.
- Used wherever producer and consumer share a clock, e.g. the AXI write-data and I2C byte queues.
- Generalises the bridge's FIFO with two read modes (standard and first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

Parameters:
DATASIZE, 8, data word width in bits.
ADDRSIZE, 4, address width; depth = 2**ADDRSIZE entries.
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
AFULL_THRESH, 2**ADDRSIZE-2, almost_full asserts when count >= AFULL_THRESH.
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  write request.
wdata  input  DATASIZE  write data.
rd_en  input  1  read request / pop.
rdata  output  DATASIZE  read data.
rvalid  output  1  standard mode: rdata valid this cycle; FWFT mode: equals !rempty.
wr_full  output  1  FIFO holds 2**ADDRSIZE entries.
rempty  output  1  FIFO holds 0 entries.
almost_full  output  1  count >= AFULL_THRESH.
almost_empty  output  1  count <= AEMPTY_THRESH.
count  output  ADDRSIZE+1  current occupancy, 0..2**ADDRSIZE.
clr_err  input  1  synchronous clear of overflow and underflow.
overflow  output  1  sticky; a write was attempted while wr_full.
underflow  output  1  sticky; a read was attempted while rempty.

Behaviour:
- Reset (rst=1, asynchronous) forces the following, and holds them while rst=1:
  - wr_ptr, rd_ptr and count = 0.
  - rempty=1, wr_full=0, almost_empty=1.
  - almost_full=0 (provided AFULL_THRESH > 0).
  - rdata=0, rvalid=0, overflow=0, underflow=0.
- Memory contents are not reset.
- Pointers are binary, ADDRSIZE+1 bits; the MSB is the wrap bit.
  - Memory address = pointer[ADDRSIZE-1:0].
  - wr_full is true when the pointers' MSBs differ and the low bits are equal.
  - rempty is true when the pointers are equal.
- Flag and count timing:
  - wr_full, rempty, almost_* and count are registered/derived from registered pointers.
  - They update on the same edge that moves the pointers.
- Write accept: do_wr = wr_en & !wr_full.
  - On accept: mem[wr_ptr] <= wdata; wr_ptr++.
  - A write while full is dropped even if rd_en is high in the same cycle, and sets overflow.
- Read accept: do_rd = rd_en & !rempty.
  - A read while empty is ignored and sets underflow.
  - A same-cycle write into an empty FIFO does not satisfy that read.
- count update per edge:
  - +1 on do_wr only.
  - -1 on do_rd only.
  - Unchanged when both or neither occur.
- Simultaneous do_wr and do_rd when neither flag is set: both pointers advance; count and flags are unchanged.
- Standard mode (FWFT=0):
  - On do_rd, rdata <= mem[rd_ptr] at the edge.
  - rvalid=1 for exactly that following cycle, otherwise 0.
  - rdata holds its last value when there is no read.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] combinationally whenever rempty=0.
  - rd_en acts as a pop acknowledge.
  - A word written into an empty FIFO appears on rdata, with rempty=0, in the cycle after the write edge.
- Wrap-around: pointers roll over modulo 2**(ADDRSIZE+1) with no special handling. Ordering is preserved across an arbitrary number of wraps.
- Sticky error flags:
  - overflow and underflow set on the edge following the offending request.
  - They hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- Reset mid-operation: all queued data is discarded immediately; after rst deasserts, the FIFO behaves as empty.
- Threshold legality: AFULL_THRESH must lie in 1..2**ADDRSIZE and AEMPTY_THRESH in 0..2**ADDRSIZE-1; this is checked with elaboration assertions.

Test Plan:
- Reset then idle (defaults): rempty=1, wr_full=0, count=0, almost_empty=1, almost_full=0, rvalid=0, overflow=underflow=0.
- Fill ordering, FWFT=0: write 0x00..0x0F over 16 cycles, then read 16 times -> wr_full=1 after the 16th write edge, almost_full=1 at count=14, rdata sequence 0x00..0x0F with rvalid one cycle after each rd_en, rempty=1 at end.
- Overflow/underflow: at full, wr_en with wdata=0xAA plus rd_en -> 0xAA is not stored, count 16->15, overflow=1. Drain, then rd_en while empty -> underflow=1. clr_err -> both 0.
- FWFT=1 latency: write 0x5C into an empty FIFO -> next cycle rempty=0 and rdata=0x5C with no rd_en. rd_en -> rempty=1 next cycle.
- Wrap and simultaneous traffic: keep count at 8 with 40 cycles of concurrent wr_en/rd_en on incrementing data -> count stays 8, output is strictly in order across 2+ pointer wraps.
- Mid-operation reset: with count=5, assert rst for 1 cycle -> count=0, rempty=1 immediately; the next write/read returns only the new data.
